// File: rtl/iter_multiplier_if.sv
// Request/response bundle between the ALU mult path and the iterative multiplier.
// The ALU side is the master: it issues a begin pulse and collects the product on mult_end.
interface iter_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               mult_begin;
  logic               mult_signed;
  logic [WIDTH-1:0]   mult_op1;
  logic [WIDTH-1:0]   mult_op2;
  logic [2*WIDTH-1:0] product;
  logic               mult_end;
  logic               busy;

  modport master (
    output mult_begin, mult_signed, mult_op1, mult_op2,
    input  product, mult_end, busy
  );

  modport slave (
    input  mult_begin, mult_signed, mult_op1, mult_op2,
    output product, mult_end, busy
  );
endinterface

// File: rtl/iter_multiplier.sv
// Multi-cycle sign-magnitude multiplier: retires BITS_PER_CYCLE multiplier bits per cycle.
// Latency WIDTH/BITS_PER_CYCLE cycles (fewer with EARLY_OUT); begin is ignored while busy.
module iter_multiplier #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 0
) (
  input  logic             clk,
  input  logic             resetn,
  iter_multiplier_if.slave bus
);
  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = WIDTH / K;
  localparam int SW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand, mplr, mplr_nxt;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] acc, acc_nxt, partial, prod_q;
  logic [SW-1:0]      step, step_nxt;
  logic [K-1:0]       digit;
  logic [31:0]        shamt;
  logic               neg, end_q, accept, finish;

  assign accept = bus.mult_begin && (state == IDLE || state == DONE);

  // Operands are stored as unsigned magnitudes; the most negative value maps to 2^(W-1).
  assign mag1 = (bus.mult_signed && bus.mult_op1[WIDTH-1]) ? -bus.mult_op1 : bus.mult_op1;
  assign mag2 = (bus.mult_signed && bus.mult_op2[WIDTH-1]) ? -bus.mult_op2 : bus.mult_op2;

  assign digit    = mplr[K-1:0];
  assign shamt    = K * 32'(step);
  assign partial  = ({{WIDTH{1'b0}}, mcand} * {{(2*WIDTH-K){1'b0}}, digit}) << shamt;
  assign acc_nxt  = acc + partial;
  assign mplr_nxt = mplr >> K;
  assign step_nxt = step + 1'b1;
  assign finish   = (step_nxt == SW'(N)) || ((EARLY_OUT != 0) && (mplr_nxt == '0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      step   <= '0;
      neg    <= 1'b0;
      prod_q <= '0;
      end_q  <= 1'b0;
    end else begin
      end_q <= 1'b0;
      if (accept) begin
        mcand <= mag1;
        mplr  <= mag2;
        neg   <= bus.mult_signed & (bus.mult_op1[WIDTH-1] ^ bus.mult_op2[WIDTH-1]);
        acc   <= '0;
        step  <= '0;
      end else if (state == RUN) begin
        acc  <= acc_nxt;
        mplr <= mplr_nxt;
        step <= step_nxt;
        // product only moves on completion; it holds through the next operation's RUN
        if (finish) begin
          prod_q <= neg ? -acc_nxt : acc_nxt;
          end_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.product  = prod_q;
  assign bus.mult_end = end_q;
  assign bus.busy     = (state == RUN);
endmodule

// File: tb/tb_iter_multiplier.sv
// Directed bench for iter_multiplier: 32b/k1, 8b/k1 with early-out, 16b/k4.
module tb_iter_multiplier;
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  iter_multiplier_if #(.WIDTH(32)) if_a ();
  iter_multiplier_if #(.WIDTH(8))  if_b ();
  iter_multiplier_if #(.WIDTH(16)) if_c ();

  iter_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(0))
    dut_a (.clk(clk), .resetn(resetn), .bus(if_a));
  iter_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1), .EARLY_OUT(1))
    dut_b (.clk(clk), .resetn(resetn), .bus(if_b));
  iter_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4), .EARLY_OUT(0))
    dut_c (.clk(clk), .resetn(resetn), .bus(if_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic go, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    case (w)
      0: begin if_a.mult_begin = go; if_a.mult_signed = s; if_a.mult_op1 = a;       if_a.mult_op2 = b;       end
      1: begin if_b.mult_begin = go; if_b.mult_signed = s; if_b.mult_op1 = a[7:0];  if_b.mult_op2 = b[7:0];  end
      default: begin if_c.mult_begin = go; if_c.mult_signed = s; if_c.mult_op1 = a[15:0]; if_c.mult_op2 = b[15:0]; end
    endcase
  endtask

  function automatic logic [63:0] prod_of(input int w);
    case (w)
      0:       return if_a.product;
      1:       return {48'b0, if_b.product};
      default: return {32'b0, if_c.product};
    endcase
  endfunction

  function automatic logic end_of(input int w);
    case (w)
      0:       return if_a.mult_end;
      1:       return if_b.mult_end;
      default: return if_c.mult_end;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return if_a.busy;
      1:       return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where mult_end is high.
  // Operands are scrambled after the begin edge to show they are latched.
  task automatic mul(input int w, input string tag, input logic s,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp_p, input int exp_lat);
    int cyc = 0;
    drive(w, 1'b1, s, a, b);
    @(negedge clk);
    drive(w, 1'b0, ~s, ~a, ~b);
    check({tag, "_busy"}, 64'(busy_of(w)), 64'd1);
    while (!end_of(w) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_prod"}, prod_of(w), exp_p);
  endtask

  initial begin
    int cyc;
    int ends;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("rst_prod", prod_of(0), 64'd0);
    check("rst_end",  64'(end_of(0)), 64'd0);
    check("rst_busy", 64'(busy_of(0)), 64'd0);
    #20;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    mul(0, "u3x8", 1'b0, 32'd3, 32'd8, 64'd24, 32);
    @(negedge clk);
    check("end_width", 64'(end_of(0)), 64'd0);
    check("idle_busy", 64'(busy_of(0)), 64'd0);
    mul(0, "u25x3", 1'b0, 32'd25, 32'd3, 64'd75, 32);
    @(negedge clk);
    mul(0, "s_m7x6", 1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 32);
    @(negedge clk);
    mul(0, "u_f9x6", 1'b0, 32'hFFFF_FFF9, 32'd6, 64'h0000_0005_FFFF_FFD6, 32);
    @(negedge clk);
    mul(0, "s_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32);
    @(negedge clk);
    mul(0, "s_zero", 1'b1, 32'd0, 32'hFFFF_FFF3, 64'd0, 32);
    @(negedge clk);
    mul(0, "s_m1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 32);
    @(negedge clk);
    mul(0, "u_maxmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
    @(negedge clk);

    // back-to-back: second begin issued in the DONE cycle must go straight to RUN
    mul(0, "b2b_1", 1'b0, 32'd2, 32'd3, 64'd6, 32);
    mul(0, "b2b_2", 1'b0, 32'd4, 32'd5, 64'd20, 32);
    @(negedge clk);

    // begin pulse in mid-RUN must be dropped
    drive(0, 1'b1, 1'b0, 32'd7, 32'd7);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    cyc = 0;
    while (!end_of(0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) drive(0, 1'b1, 1'b0, 32'd100, 32'd100);
      else          drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    check("ign_lat", 64'(cyc), 64'd32);
    check("ign_prod", prod_of(0), 64'd49);
    @(negedge clk);
    check("ign_idle", 64'(busy_of(0)), 64'd0);

    // async reset around step 10 of RUN
    drive(0, 1'b1, 1'b0, 32'd123, 32'd456);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mrst_prod", prod_of(0), 64'd0);
    check("mrst_busy", 64'(busy_of(0)), 64'd0);
    check("mrst_end",  64'(end_of(0)), 64'd0);
    resetn = 1'b1;
    ends = 0;
    repeat (40) begin
      @(negedge clk);
      if (end_of(0)) ends++;
    end
    check("mrst_no_end", 64'(ends), 64'd0);
    mul(0, "post_rst", 1'b0, 32'd9, 32'd1, 64'd9, 32);
    @(negedge clk);

    // early-out, 8-bit, k=1: latency tracks the highest set multiplier magnitude bit
    mul(1, "eo_x1", 1'b0, 32'd37, 32'd1, 64'd37, 1);
    @(negedge clk);
    mul(1, "eo_x0", 1'b0, 32'd37, 32'd0, 64'd0, 1);
    @(negedge clk);
    mul(1, "eo_m3x5", 1'b1, 32'hFD, 32'd5, 64'hFFF1, 3);
    @(negedge clk);
    mul(1, "eo_m3m5", 1'b1, 32'hFD, 32'hFB, 64'd15, 3);
    @(negedge clk);
    mul(1, "eo_minmin", 1'b1, 32'h80, 32'h80, 64'h4000, 8);
    @(negedge clk);

    // 16-bit, 4 bits per cycle
    mul(2, "k4_s", 1'b1, 32'hFB2E, 32'd567, 64'hFFF5_52E2, 4);
    @(negedge clk);
    mul(2, "k4_u", 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE_0001, 4);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
